cfu_cmd_driver: RTL and testbench

- Initiator side of the CFU command/response protocol; issues `cmd_*` transactions to the Cfu responder and collects `rsp_*`.
- Lets a DMA/sequencer stream A/B buffer writes, compute and read-back commands without a CPU, through a small request FIFO.
- Sits between the sequencer (request/response valid-ready ports) and the Cfu `cmd`/`rsp` ports.
- Only one CFU transaction is outstanding at a time.

---
 rtl/cfu_cmd_driver_if.sv | 23 ++
 rtl/cfu_cmd_driver.sv | 179 +++++++++++++++++
 tb/tb_cfu_cmd_driver.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cfu_cmd_driver_if.sv
// CFU command/response bus: the driver is the master and the Cfu responder is the slave.
interface cfu_cmd_driver_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [9:0]  cmd_payload_function_id;
    logic [31:0] cmd_payload_inputs_0;
    logic [31:0] cmd_payload_inputs_1;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_payload_outputs_0;

    modport master (
        output cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1,
        output rsp_ready,
        input  cmd_ready, rsp_valid, rsp_payload_outputs_0
    );

    modport slave (
        input  cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1,
        input  rsp_ready,
        output cmd_ready, rsp_valid, rsp_payload_outputs_0
    );
endinterface

// File: rtl/cfu_cmd_driver.sv
// CFU initiator: queues sequencer requests in a small FIFO and issues them one at a time.
// Optional macro CFU_DRV_TIMEOUT_EN adds an ISSUE/WAIT_RSP watchdog and a sticky timeout_err output.
module cfu_cmd_driver #(
    parameter int unsigned FIFO_AW        = 2,
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [9:0]       req_function_id,
    input  logic [31:0]      req_inputs_0,
    input  logic [31:0]      req_inputs_1,
    input  logic             req_discard,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [9:0]       out_function_id,
    cfu_cmd_driver_if.master cfu,
    output logic             busy,
    output logic [CNT_W-1:0] done_count
`ifdef CFU_DRV_TIMEOUT_EN
    ,
    output logic             timeout_err
`endif
);

    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned EW    = 75;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP} state_t;

    state_t state, state_next;

    logic [EW-1:0]    mem [DEPTH];
    logic [FIFO_AW:0] wr_ptr, rd_ptr;
    logic [EW-1:0]    head;
    logic             empty, full, push, pop;

    logic             cmd_valid_q, discard_q, rsp_ready_c;
    logic [9:0]       fid_q;
    logic [31:0]      in0_q, in1_q;
    logic             cmd_fire, rsp_fire, abort, timeout_hit;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                       (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
    assign req_ready = !full;
    assign push      = req_valid && !full;
    assign head      = mem[rd_ptr[FIFO_AW-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[FIFO_AW-1:0]] <= {req_discard, req_function_id, req_inputs_1, req_inputs_0};
        end
    end

    assign rsp_ready_c = (state == WAIT_RSP) && (discard_q || !out_valid);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        cmd_fire   = 1'b0;
        rsp_fire   = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (timeout_hit) begin
                    abort      = 1'b1;
                    state_next = IDLE;
                end else if (cmd_valid_q && cfu.cmd_ready) begin
                    cmd_fire   = 1'b1;
                    state_next = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                // A response that actually transfers completes even on the watchdog cycle.
                if (cfu.rsp_valid && rsp_ready_c) begin
                    rsp_fire   = 1'b1;
                    state_next = IDLE;
                end else if (timeout_hit) begin
                    abort      = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            cmd_valid_q     <= 1'b0;
            discard_q       <= 1'b0;
            fid_q           <= '0;
            in0_q           <= '0;
            in1_q           <= '0;
            out_valid       <= 1'b0;
            out_data        <= '0;
            out_function_id <= '0;
            done_count      <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + {{FIFO_AW{1'b0}}, 1'b1};
            if (pop) begin
                rd_ptr                           <= rd_ptr + {{FIFO_AW{1'b0}}, 1'b1};
                {discard_q, fid_q, in1_q, in0_q} <= head;
            end

            // cmd_valid rises one cycle after entering ISSUE and drops only on handshake or abort.
            if (cmd_fire || abort) begin
                cmd_valid_q <= 1'b0;
            end else if (state == ISSUE) begin
                cmd_valid_q <= 1'b1;
            end

            if (rsp_fire) done_count <= done_count + {{(CNT_W-1){1'b0}}, 1'b1};

            if (rsp_fire && !discard_q) begin
                out_valid       <= 1'b1;
                out_data        <= cfu.rsp_payload_outputs_0;
                out_function_id <= fid_q;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef CFU_DRV_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] tcnt;

    assign timeout_hit = (state != IDLE) && (tcnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tcnt        <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (pop) begin
                tcnt <= '0;
            end else if (state != IDLE) begin
                tcnt <= tcnt + {{(TW-1){1'b0}}, 1'b1};
            end
            if (abort) timeout_err <= 1'b1;
        end
    end
`else
    logic unused_timeout;

    assign timeout_hit    = 1'b0;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    assign cfu.cmd_valid               = cmd_valid_q;
    assign cfu.cmd_payload_function_id = fid_q;
    assign cfu.cmd_payload_inputs_0    = in0_q;
    assign cfu.cmd_payload_inputs_1    = in1_q;
    assign cfu.rsp_ready               = rsp_ready_c;

    assign busy = !empty || (state != IDLE) || out_valid;

endmodule

// File: tb/tb_cfu_cmd_driver.sv
// Directed bench for cfu_cmd_driver; the Cfu side is driven step by step from the stimulus sequence.
module tb_cfu_cmd_driver;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid, req_ready, req_discard;
    logic [9:0]  req_function_id;
    logic [31:0] req_inputs_0, req_inputs_1;
    logic        out_valid, out_ready;
    logic [31:0] out_data;
    logic [9:0]  out_function_id;
    logic        busy;
    logic [15:0] done_count;
`ifdef CFU_DRV_TIMEOUT_EN
    logic        timeout_err;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cfu_cmd_driver_if cfu ();

    cfu_cmd_driver #(
        .FIFO_AW(2),
        .TIMEOUT_CYCLES(8),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_function_id(req_function_id),
        .req_inputs_0(req_inputs_0),
        .req_inputs_1(req_inputs_1),
        .req_discard(req_discard),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_function_id(out_function_id),
        .cfu(cfu),
        .busy(busy),
        .done_count(done_count)
`ifdef CFU_DRV_TIMEOUT_EN
        ,
        .timeout_err(timeout_err)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic v, input logic [9:0] f, input logic [31:0] a,
                           input logic [31:0] b, input logic d);
        req_valid       = v;
        req_function_id = f;
        req_inputs_0    = a;
        req_inputs_1    = b;
        req_discard     = d;
    endtask

    initial begin
        reset_n   = 1'b0;
        out_ready = 1'b0;
        set_req(1'b0, 10'h0, 32'h0, 32'h0, 1'b0);
        cfu.cmd_ready             = 1'b0;
        cfu.rsp_valid             = 1'b0;
        cfu.rsp_payload_outputs_0 = 32'h0;
        tick; tick;
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_cmd_valid", 64'(cfu.cmd_valid), 64'd0);
        chk("rst_rsp_ready", 64'(cfu.rsp_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done_count), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_cmd_fid", 64'(cfu.cmd_payload_function_id), 64'd0);
        reset_n = 1'b1;
        tick;

        // Single discarded write with a zero-wait Cfu
        cfu.cmd_ready             = 1'b1;
        cfu.rsp_valid             = 1'b1;
        cfu.rsp_payload_outputs_0 = 32'hDEAD_BEEF;
        set_req(1'b1, 10'h009, 32'd5, 32'h7F, 1'b1);
        tick;
        set_req(1'b0, 10'h0, 32'h0, 32'h0, 1'b0);
        chk("w_cv_t1", 64'(cfu.cmd_valid), 64'd0);
        chk("w_busy", 64'(busy), 64'd1);
        tick;
        chk("w_cv_t2", 64'(cfu.cmd_valid), 64'd0);
        tick;
        chk("w_cv_t3", 64'(cfu.cmd_valid), 64'd1);
        chk("w_fid", 64'(cfu.cmd_payload_function_id), 64'h009);
        chk("w_in0", 64'(cfu.cmd_payload_inputs_0), 64'd5);
        chk("w_in1", 64'(cfu.cmd_payload_inputs_1), 64'h7F);
        tick;
        chk("w_cv_drop", 64'(cfu.cmd_valid), 64'd0);
        chk("w_rsp_ready", 64'(cfu.rsp_ready), 64'd1);
        tick;
        chk("w_done", 64'(done_count), 64'd1);
        chk("w_out_valid", 64'(out_valid), 64'd0);
        chk("w_busy_end", 64'(busy), 64'd0);

        // Compute followed by read-back
        cfu.rsp_valid = 1'b0;
        set_req(1'b1, 10'h002, 32'd16, 32'd128, 1'b0);
        tick;
        set_req(1'b1, 10'h003, 32'd1, 32'd0, 1'b0);
        tick;
        set_req(1'b0, 10'h0, 32'h0, 32'h0, 1'b0);
        tick;
        chk("c_cv", 64'(cfu.cmd_valid), 64'd1);
        chk("c_fid", 64'(cfu.cmd_payload_function_id), 64'h002);
        chk("c_in0", 64'(cfu.cmd_payload_inputs_0), 64'd16);
        chk("c_in1", 64'(cfu.cmd_payload_inputs_1), 64'd128);
        tick;
        cfu.rsp_valid             = 1'b1;
        cfu.rsp_payload_outputs_0 = 32'h55;
        chk("c_rsp_ready", 64'(cfu.rsp_ready), 64'd1);
        tick;
        cfu.rsp_valid = 1'b0;
        chk("c_out_valid", 64'(out_valid), 64'd1);
        chk("c_out_data", 64'(out_data), 64'h55);
        chk("c_out_fid", 64'(out_function_id), 64'h002);
        tick;
        out_ready = 1'b1;
        chk("c_out_hold", 64'(out_valid), 64'd1);
        tick;
        out_ready = 1'b0;
        chk("c_out_clr", 64'(out_valid), 64'd0);
        chk("r_cv", 64'(cfu.cmd_valid), 64'd1);
        chk("r_fid", 64'(cfu.cmd_payload_function_id), 64'h003);
        tick;
        cfu.rsp_valid             = 1'b1;
        cfu.rsp_payload_outputs_0 = 32'h1234_ABCD;
        tick;
        cfu.rsp_valid = 1'b0;
        chk("r_out_valid", 64'(out_valid), 64'd1);
        chk("r_out_data", 64'(out_data), 64'h1234_ABCD);
        chk("r_out_fid", 64'(out_function_id), 64'h003);
        chk("r_done", 64'(done_count), 64'd3);
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        chk("r_out_clr", 64'(out_valid), 64'd0);
        chk("r_busy", 64'(busy), 64'd0);

        // Back-pressure: three non-discard commands with out_ready low
        cfu.rsp_valid             = 1'b1;
        cfu.rsp_payload_outputs_0 = 32'hD1;
        set_req(1'b1, 10'h011, 32'h101, 32'h0, 1'b0);
        tick;
        set_req(1'b1, 10'h012, 32'h102, 32'h0, 1'b0);
        tick;
        set_req(1'b1, 10'h013, 32'h103, 32'h0, 1'b0);
        tick;
        set_req(1'b0, 10'h0, 32'h0, 32'h0, 1'b0);
        chk("bp_cv1", 64'(cfu.cmd_valid), 64'd1);
        chk("bp_fid1", 64'(cfu.cmd_payload_function_id), 64'h011);
        tick; tick;
        chk("bp_ov1", 64'(out_valid), 64'd1);
        chk("bp_data1", 64'(out_data), 64'hD1);
        chk("bp_ofid1", 64'(out_function_id), 64'h011);
        cfu.rsp_payload_outputs_0 = 32'hD2;
        tick; tick; tick;
        chk("bp_blk_a", 64'(cfu.rsp_ready), 64'd0);
        tick;
        chk("bp_blk_b", 64'(cfu.rsp_ready), 64'd0);
        chk("bp_no_cv3", 64'(cfu.cmd_valid), 64'd0);
        chk("bp_data_held", 64'(out_data), 64'hD1);
        chk("bp_done_held", 64'(done_count), 64'd4);
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        chk("bp_ov_clr", 64'(out_valid), 64'd0);
        chk("bp_unblk", 64'(cfu.rsp_ready), 64'd1);
        tick;
        chk("bp_ov2", 64'(out_valid), 64'd1);
        chk("bp_data2", 64'(out_data), 64'hD2);
        chk("bp_ofid2", 64'(out_function_id), 64'h012);
        cfu.rsp_payload_outputs_0 = 32'hD3;
        tick; tick;
        chk("bp_cv3", 64'(cfu.cmd_valid), 64'd1);
        chk("bp_fid3", 64'(cfu.cmd_payload_function_id), 64'h013);
        chk("bp_in0_3", 64'(cfu.cmd_payload_inputs_0), 64'h103);
        tick;
        chk("bp_blk_c", 64'(cfu.rsp_ready), 64'd0);
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        tick;
        chk("bp_ov3", 64'(out_valid), 64'd1);
        chk("bp_data3", 64'(out_data), 64'hD3);
        chk("bp_ofid3", 64'(out_function_id), 64'h013);
        chk("bp_done", 64'(done_count), 64'd6);
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        chk("bp_ov_end", 64'(out_valid), 64'd0);

        // FIFO full while the Cfu stalls cmd_ready
        cfu.cmd_ready = 1'b0;
        cfu.rsp_valid = 1'b0;
        set_req(1'b1, 10'h021, 32'd1, 32'd0, 1'b1);
        tick;
        chk("f_rdy1", 64'(req_ready), 64'd1);
        set_req(1'b1, 10'h022, 32'd2, 32'd0, 1'b1);
        tick;
        set_req(1'b1, 10'h023, 32'd3, 32'd0, 1'b1);
        tick;
        set_req(1'b1, 10'h024, 32'd4, 32'd0, 1'b1);
        tick;
        chk("f_rdy4", 64'(req_ready), 64'd1);
        set_req(1'b1, 10'h025, 32'd5, 32'd0, 1'b1);
        tick;
        chk("f_full", 64'(req_ready), 64'd0);
        set_req(1'b1, 10'h026, 32'd6, 32'd0, 1'b1);
        tick;
        chk("f_full_hold", 64'(req_ready), 64'd0);
        set_req(1'b0, 10'h0, 32'h0, 32'h0, 1'b0);
        cfu.cmd_ready = 1'b1;
        cfu.rsp_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("f_cv", 64'(cfu.cmd_valid), 64'd1);
            chk("f_fid", 64'(cfu.cmd_payload_function_id), 64'(10'h021 + 10'(k)));
            tick; tick; tick; tick;
        end
        chk("f_cv_end", 64'(cfu.cmd_valid), 64'd0);
        chk("f_busy_end", 64'(busy), 64'd0);
        chk("f_done", 64'(done_count), 64'd11);
        chk("f_rdy_end", 64'(req_ready), 64'd1);

        // Asynchronous reset during WAIT_RSP
        cfu.rsp_valid = 1'b0;
        set_req(1'b1, 10'h031, 32'd0, 32'd0, 1'b0);
        tick;
        set_req(1'b1, 10'h032, 32'd0, 32'd0, 1'b0);
        tick;
        set_req(1'b0, 10'h0, 32'h0, 32'h0, 1'b0);
        tick; tick;
        cfu.rsp_valid             = 1'b1;
        cfu.rsp_payload_outputs_0 = 32'h77;
        tick;
        cfu.rsp_valid = 1'b0;
        tick;
        set_req(1'b1, 10'h033, 32'd0, 32'd0, 1'b0);
        tick;
        set_req(1'b0, 10'h0, 32'h0, 32'h0, 1'b0);
        tick;
        chk("x_ov_pre", 64'(out_valid), 64'd1);
        chk("x_rr_pre", 64'(cfu.rsp_ready), 64'd0);
        chk("x_busy_pre", 64'(busy), 64'd1);
        chk("x_done_pre", 64'(done_count), 64'd12);
        #2;
        reset_n = 1'b0;
        #1;
        chk("x_cv", 64'(cfu.cmd_valid), 64'd0);
        chk("x_rr", 64'(cfu.rsp_ready), 64'd0);
        chk("x_ov", 64'(out_valid), 64'd0);
        chk("x_busy", 64'(busy), 64'd0);
        chk("x_done", 64'(done_count), 64'd0);
        chk("x_out_data", 64'(out_data), 64'd0);
        chk("x_cmd_fid", 64'(cfu.cmd_payload_function_id), 64'd0);
        tick;
        reset_n = 1'b1;
        tick; tick;
        chk("x_cv_post", 64'(cfu.cmd_valid), 64'd0);
        chk("x_busy_post", 64'(busy), 64'd0);
        chk("x_done_post", 64'(done_count), 64'd0);
        chk("x_rdy_post", 64'(req_ready), 64'd1);

`ifdef CFU_DRV_TIMEOUT_EN
        // Watchdog with TIMEOUT_CYCLES = 8 and a Cfu that never responds
        chk("t_err_init", 64'(timeout_err), 64'd0);
        cfu.rsp_valid = 1'b0;
        cfu.cmd_ready = 1'b1;
        set_req(1'b1, 10'h041, 32'd0, 32'd0, 1'b0);
        tick;
        set_req(1'b1, 10'h042, 32'd0, 32'd0, 1'b1);
        tick;
        set_req(1'b0, 10'h0, 32'h0, 32'h0, 1'b0);
        repeat (7) tick;
        chk("t_err_pre", 64'(timeout_err), 64'd0);
        chk("t_rr_pre", 64'(cfu.rsp_ready), 64'd1);
        tick;
        chk("t_err", 64'(timeout_err), 64'd1);
        chk("t_rr", 64'(cfu.rsp_ready), 64'd0);
        chk("t_cv", 64'(cfu.cmd_valid), 64'd0);
        chk("t_done", 64'(done_count), 64'd0);
        tick; tick;
        chk("t_next_cv", 64'(cfu.cmd_valid), 64'd1);
        chk("t_next_fid", 64'(cfu.cmd_payload_function_id), 64'h042);
        cfu.rsp_valid = 1'b1;
        tick; tick;
        chk("t_next_done", 64'(done_count), 64'd1);
        chk("t_err_sticky", 64'(timeout_err), 64'd1);
        chk("t_busy", 64'(busy), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
